nios2_qsys_0_oci_dct_packer: RTL and testbench
==============================================

# nios2_qsys_0_oci_dct_packer

Producer side of the OCI data-compressed-trace (DCT) path. It packs a stream of 2-bit trace codes into a 30-bit shift buffer with a 4-bit slot count and emits each completed or flushed buffer as a frame over a valid/ready handshake. It also sequences end-of-test, driving `test_ending` and `test_has_ended` to the OCI test bench monitor that consumes `dct_buffer`, `dct_count`, `test_ending` and `test_has_ended`.

## Interface
- `MAX_SLOTS`, default 15: number of 2-bit slots per frame. Legal range is 1..15.
- `clk`  in  1: single clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `code_valid`  in  1: a trace code is presented this cycle. The source cannot stall.
- `code`  in  2: trace code.
- `flush`  in  1: single-cycle request to emit the partial buffer.
- `test_end_req`  in  1: level or pulse that starts the end-of-test sequence.
- `frame_ready`  in  1: downstream accepts the frame.
- `frame_valid`  out  1: frame holding register is occupied.
- `frame_data`  out  30: packed codes, right-aligned, with the oldest code in the highest occupied slot.
- `frame_count`  out  4: number of valid slots in `frame_data`, 1..MAX_SLOTS.
- `dct_buffer`  out  30: live accumulator.
- `dct_count`  out  4: live accumulator slot count.
- `overflow`  out  1: sticky flag, set when a code is dropped. Cleared only by reset.
- `test_ending`  out  1: end sequence in progress.
- `test_has_ended`  out  1: end sequence complete.

## Operation
- **Reset values.** All outputs and the internal flush-pending flag reset to 0. The state machine resets to RUN.
- **Frame-register free condition.** `free = !frame_valid || frame_ready`.
- **Accept (RUN only).** On `code_valid`:
  - `dct_buffer <= {dct_buffer[27:0], code}`
  - `dct_count <= dct_count + 1`
- **Completion.** An accept with `dct_count == MAX_SLOTS-1` completes the frame.
  - If `free`: load `frame_data`/`frame_count` with the post-shift buffer and `MAX_SLOTS`. Set `frame_valid` and clear the accumulator to 0/0.
  - If not `free`: drop the code, leave the accumulator unchanged, and set `overflow`.
- **Flush.**
  - Flush with `dct_count == 0` (after any same-cycle accept) has no effect.
  - Flush in the same cycle as an accept: the code is included first, then the flush applies. If that accept completes the frame, the flush is satisfied by the completion and has no further effect.
  - Otherwise, if `free`: emit a partial frame with `frame_count = dct_count` (post-accept) and clear the accumulator.
  - If not `free`: set flush-pending. The flush is re-attempted every cycle until the frame register is free.
  - While flush-pending, newly accepted codes join the pending frame. Completion rules still apply.
- **Frame hold.** `frame_valid` holds until a cycle with `frame_ready`. `frame_data` and `frame_count` are stable while `frame_valid` is high. A new frame may load in the same cycle as the old one is taken, giving back-to-back frames.
- **State machine.**
  - RUN → ENDING on `test_end_req`. This forces a flush (pending if not `free`).
  - ENDING: `test_ending = 1`. `code_valid` is ignored; codes are discarded without setting `overflow`.
  - ENDING → ENDED when `dct_count == 0`, flush-pending is 0 and `frame_valid == 0`.
  - ENDED: `test_ending = 1` and `test_has_ended = 1`. The block stays in ENDED until reset. `test_end_req` is ignored outside RUN.
- **Reset mid-operation.** Reset discards the accumulator, any pending frame and the end state immediately. No frame is emitted.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- Code to `dct_buffer`/`dct_count`: 1 cycle.
- Completing accept or effective flush to `frame_valid` high: 1 cycle.
- Frame transfer occurs on a clock edge where `frame_valid && frame_ready`. `frame_valid` falls the next cycle unless a new frame loads.
- `test_ending` rises 1 cycle after `test_end_req` is sampled in RUN.
- `test_has_ended` rises 1 cycle after the drain condition holds in ENDING.
- Throughput: one code per cycle sustained while `frame_ready` is held high.

## Test plan
- **Basic pack.** Reset, hold `frame_ready = 1`, send 15 codes 0,1,2,3,0,1,... → after the 15th, `frame_valid` = 1 for one cycle with `frame_data = 30'h06C6C6C6` (15 slots, oldest first) and `frame_count = 15`. `dct_count` returns to 0.
- **Partial flush.** Send codes 3,2,1, then `flush` → frame with `frame_data = 30'h39` and `frame_count = 3`. A second flush with `dct_count == 0` produces no frame.
- **Backpressure and overflow.** Hold `frame_ready = 0`, send 31 codes → first frame held with stable data. Accumulator stops at 14. The 30th and 31st codes are dropped and `overflow = 1`. Raise `frame_ready` → `overflow` stays 1.
- **Flush while busy plus simultaneous accept.** Frame held, then flush with a same-cycle code at `dct_count = 2` → pending. Release `frame_ready` → next frame has `frame_count = 3`, back-to-back with no bubble.
- **End of test.** `dct_count = 5`, `frame_ready = 0`, assert `test_end_req` → `test_ending = 1` the next cycle. Codes are ignored and `overflow` stays 0. Release `frame_ready` → 5-slot frame drains, then `test_has_ended = 1` and stays set.
- **Async reset mid-frame.** Assert `reset_n = 0` between clock edges while `frame_valid` and ENDING are active → all outputs are 0 immediately. After release, the block is in RUN with `dct_count = 0`.

Source files
------------

// File: rtl/nios2_qsys_0_oci_dct_packer_if.sv
// Frame handshake between the DCT packer (master) and the frame consumer (slave).
//   frame_valid : frame holding register occupied (master -> slave)
//   frame_ready : consumer accepts the frame this cycle (slave -> master)
//   frame_data  : packed 2-bit codes, right-aligned, oldest in highest slot
//   frame_count : number of valid slots in frame_data
interface nios2_qsys_0_oci_dct_packer_if;
  logic        frame_valid;
  logic        frame_ready;
  logic [29:0] frame_data;
  logic [3:0]  frame_count;

  modport master (
    output frame_valid,
    output frame_data,
    output frame_count,
    input  frame_ready
  );

  modport slave (
    input  frame_valid,
    input  frame_data,
    input  frame_count,
    output frame_ready
  );
endinterface

// File: rtl/nios2_qsys_0_oci_dct_packer.sv
// OCI data-compressed-trace packer.
// Packs 2-bit trace codes into a 30-bit shift buffer, emits full or flushed
// buffers as frames over a valid/ready handshake, and sequences end-of-test.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   code_valid, code      : trace code input (source cannot stall)
//   flush                 : single-cycle request to emit the partial buffer
//   test_end_req          : starts the end-of-test sequence (RUN only)
//   frame                 : frame handshake (master modport)
//   dct_buffer, dct_count : live accumulator and its slot count
//   overflow              : sticky, set when a completing code is dropped
//   test_ending           : end sequence in progress
//   test_has_ended        : end sequence complete
module nios2_qsys_0_oci_dct_packer #(
  parameter int unsigned MAX_SLOTS = 15
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                code_valid,
  input  logic [1:0]                          code,
  input  logic                                flush,
  input  logic                                test_end_req,
  nios2_qsys_0_oci_dct_packer_if.master       frame,
  output logic [29:0]                         dct_buffer,
  output logic [3:0]                          dct_count,
  output logic                                overflow,
  output logic                                test_ending,
  output logic                                test_has_ended
);

  localparam logic [3:0] FULL_CNT = 4'(MAX_SLOTS);
  localparam logic [3:0] LAST_CNT = 4'(MAX_SLOTS - 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_ENDING,
    ST_ENDED
  } state_e;

  state_e      state_q, state_d;
  logic [29:0] buf_q, buf_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        fv_q, fv_d;
  logic [29:0] fdata_q, fdata_d;
  logic [3:0]  fcnt_q, fcnt_d;
  logic        ovf_q, ovf_d;
  logic        pend_q, pend_d;
  logic        ending_q, ending_d;
  logic        ended_q, ended_d;

  logic        free;
  logic        run;
  logic        flush_req;
  logic        completed;

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    fv_d      = fv_q;
    fdata_d   = fdata_q;
    fcnt_d    = fcnt_q;
    ovf_d     = ovf_q;
    pend_d    = pend_q;
    completed = 1'b0;

    free      = !fv_q || frame.frame_ready;
    run       = (state_q == ST_RUN);
    // Entering ENDING forces a flush; a pending flush retries every cycle.
    flush_req = flush || pend_q || (run && test_end_req);

    if (fv_q && frame.frame_ready) begin
      fv_d = 1'b0;
    end

    if (run && code_valid) begin
      if (cnt_q == LAST_CNT) begin
        if (free) begin
          fv_d      = 1'b1;
          fdata_d   = {buf_q[27:0], code};
          fcnt_d    = FULL_CNT;
          buf_d     = '0;
          cnt_d     = '0;
          completed = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end else begin
        buf_d = {buf_q[27:0], code};
        cnt_d = cnt_q + 4'd1;
      end
    end

    // Flush acts on the post-accept accumulator; a completion satisfies it.
    if (completed) begin
      pend_d = 1'b0;
    end else if (flush_req) begin
      if (cnt_d == '0) begin
        pend_d = 1'b0;
      end else if (free) begin
        fv_d    = 1'b1;
        fdata_d = buf_d;
        fcnt_d  = cnt_d;
        buf_d   = '0;
        cnt_d   = '0;
        pend_d  = 1'b0;
      end else begin
        pend_d = 1'b1;
      end
    end

    case (state_q)
      ST_RUN:    if (test_end_req) state_d = ST_ENDING;
      ST_ENDING: if (cnt_q == '0 && !pend_q && !fv_q) state_d = ST_ENDED;
      ST_ENDED:  state_d = ST_ENDED;
      default:   state_d = ST_RUN;
    endcase

    ending_d = (state_d != ST_RUN);
    ended_d  = (state_d == ST_ENDED);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_RUN;
      buf_q    <= '0;
      cnt_q    <= '0;
      fv_q     <= 1'b0;
      fdata_q  <= '0;
      fcnt_q   <= '0;
      ovf_q    <= 1'b0;
      pend_q   <= 1'b0;
      ending_q <= 1'b0;
      ended_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      fv_q     <= fv_d;
      fdata_q  <= fdata_d;
      fcnt_q   <= fcnt_d;
      ovf_q    <= ovf_d;
      pend_q   <= pend_d;
      ending_q <= ending_d;
      ended_q  <= ended_d;
    end
  end

  assign frame.frame_valid = fv_q;
  assign frame.frame_data  = fdata_q;
  assign frame.frame_count = fcnt_q;
  assign dct_buffer        = buf_q;
  assign dct_count         = cnt_q;
  assign overflow          = ovf_q;
  assign test_ending       = ending_q;
  assign test_has_ended    = ended_q;

endmodule

// File: tb/tb_nios2_qsys_0_oci_dct_packer.sv
// Self-checking bench for nios2_qsys_0_oci_dct_packer.
// Expected frames are pushed to a scoreboard queue as stimulus is driven and
// popped by a monitor whenever the DUT transfers a frame.
module tb_nios2_qsys_0_oci_dct_packer;

  logic        clk;
  logic        reset_n;
  logic        code_valid;
  logic [1:0]  code;
  logic        flush;
  logic        test_end_req;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        overflow;
  logic        test_ending;
  logic        test_has_ended;

  nios2_qsys_0_oci_dct_packer_if pif ();

  nios2_qsys_0_oci_dct_packer #(.MAX_SLOTS(15)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .code_valid     (code_valid),
    .code           (code),
    .flush          (flush),
    .test_end_req   (test_end_req),
    .frame          (pif.master),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .overflow       (overflow),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // {count, data}
  logic [33:0] sb[$];
  logic [29:0] m_buf;
  int          m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_buf = '0;
    m_cnt = 0;
  endtask

  task automatic model_accept(input logic [1:0] c);
    m_buf = {m_buf[27:0], c};
    m_cnt++;
    if (m_cnt == 15) begin
      sb.push_back({4'd15, m_buf});
      model_clear();
    end
  endtask

  task automatic model_flush();
    if (m_cnt != 0) sb.push_back({4'(m_cnt), m_buf});
    model_clear();
  endtask

  task automatic send(input logic [1:0] c, input bit acc);
    code_valid = 1'b1;
    code       = c;
    if (acc) model_accept(c);
    step();
    code_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    model_clear();
    step();
  endtask

  // Monitor: frame transfer happens at the next posedge when valid && ready.
  always @(negedge clk) begin
    if (reset_n && pif.frame_valid && pif.frame_ready) begin
      if (sb.size() == 0) begin
        check_eq("frame_unexpected", {28'd0, pif.frame_count}, 32'd0);
      end else begin
        logic [33:0] e;
        e = sb.pop_front();
        check_eq("frame_data", {2'b0, pif.frame_data}, {2'b0, e[29:0]});
        check_eq("frame_count", {28'd0, pif.frame_count}, {28'd0, e[33:30]});
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n         = 1'b0;
    code_valid      = 1'b0;
    code            = 2'd0;
    flush           = 1'b0;
    test_end_req    = 1'b0;
    pif.frame_ready = 1'b0;
    model_clear();
    #1;
    check_eq("rst_fv", {31'd0, pif.frame_valid}, 32'd0);
    check_eq("rst_dct_count", {28'd0, dct_count}, 32'd0);
    check_eq("rst_flags", {29'd0, overflow, test_ending, test_has_ended}, 32'd0);
    step();
    step();
    reset_n = 1'b1;
    step();

    // Basic pack: 15 codes with sink always ready.
    pif.frame_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      send(2'(i % 4), 1'b1);
      if (i == 2) begin
        check_eq("pack_cnt3", {28'd0, dct_count}, 32'd3);
        check_eq("pack_buf3", {2'b0, dct_buffer}, 32'h6);
      end
    end
    check_eq("pack_fv", {31'd0, pif.frame_valid}, 32'd1);
    check_eq("pack_data", {2'b0, pif.frame_data}, 32'h06C6C6C6);
    check_eq("pack_cnt0", {28'd0, dct_count}, 32'd0);
    step();
    check_eq("pack_fv_fall", {31'd0, pif.frame_valid}, 32'd0);

    // Partial flush, then a flush with an empty accumulator.
    send(2'd3, 1'b1);
    send(2'd2, 1'b1);
    send(2'd1, 1'b1);
    flush = 1'b1;
    model_flush();
    step();
    flush = 1'b0;
    check_eq("pflush_data", {2'b0, pif.frame_data}, 32'h39);
    check_eq("pflush_cnt", {28'd0, pif.frame_count}, 32'd3);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("empty_flush_fv", {31'd0, pif.frame_valid}, 32'd0);

    // Backpressure and overflow.
    pif.frame_ready = 1'b0;
    for (int k = 0; k < 31; k++) begin
      send(2'(k % 4), k <= 28);
      if (k == 28) begin
        check_eq("bp_ovf_pre", {31'd0, overflow}, 32'd0);
        check_eq("bp_cnt14", {28'd0, dct_count}, 32'd14);
      end
      if (k == 29) check_eq("bp_ovf_set", {31'd0, overflow}, 32'd1);
    end
    check_eq("bp_cnt_hold", {28'd0, dct_count}, 32'd14);
    check_eq("bp_fv_hold", {31'd0, pif.frame_valid}, 32'd1);
    check_eq("bp_data_stable", {2'b0, pif.frame_data}, 32'h06C6C6C6);
    pif.frame_ready = 1'b1;
    step();
    check_eq("bp_ovf_sticky", {31'd0, overflow}, 32'd1);
    send(2'd1, 1'b1);
    check_eq("bp_refill_fv", {31'd0, pif.frame_valid}, 32'd1);
    step();

    // Flush while busy with a same-cycle accept, then back-to-back frames.
    pif.frame_ready = 1'b0;
    for (int i = 0; i < 15; i++) send(2'(3 - (i % 4)), 1'b1);
    send(2'd2, 1'b1);
    send(2'd1, 1'b1);
    code_valid = 1'b1;
    code       = 2'd3;
    flush      = 1'b1;
    model_accept(2'd3);
    model_flush();
    step();
    code_valid = 1'b0;
    flush      = 1'b0;
    check_eq("pend_cnt", {28'd0, dct_count}, 32'd3);
    check_eq("pend_old_cnt", {28'd0, pif.frame_count}, 32'd15);
    step();
    check_eq("pend_hold_cnt", {28'd0, dct_count}, 32'd3);
    pif.frame_ready = 1'b1;
    step();
    check_eq("b2b_fv", {31'd0, pif.frame_valid}, 32'd1);
    check_eq("b2b_cnt", {28'd0, pif.frame_count}, 32'd3);
    check_eq("b2b_acc0", {28'd0, dct_count}, 32'd0);
    step();
    check_eq("b2b_fv_fall", {31'd0, pif.frame_valid}, 32'd0);
    check_eq("sb_drain_a", sb.size(), 32'd0);

    // End of test.
    do_reset();
    pif.frame_ready = 1'b0;
    send(2'd2, 1'b1);
    send(2'd2, 1'b1);
    send(2'd1, 1'b1);
    send(2'd3, 1'b1);
    send(2'd0, 1'b1);
    check_eq("end_cnt5", {28'd0, dct_count}, 32'd5);
    test_end_req = 1'b1;
    model_flush();
    step();
    test_end_req = 1'b0;
    check_eq("end_ending", {31'd0, test_ending}, 32'd1);
    check_eq("end_not_ended", {31'd0, test_has_ended}, 32'd0);
    check_eq("end_frame_cnt", {28'd0, pif.frame_count}, 32'd5);
    for (int i = 0; i < 3; i++) send(2'(i), 1'b0);
    check_eq("end_ovf0", {31'd0, overflow}, 32'd0);
    check_eq("end_codes_ignored", {28'd0, dct_count}, 32'd0);
    pif.frame_ready = 1'b1;
    step();
    check_eq("end_fv_fall", {31'd0, pif.frame_valid}, 32'd0);
    check_eq("end_not_yet", {31'd0, test_has_ended}, 32'd0);
    step();
    check_eq("end_ended", {31'd0, test_has_ended}, 32'd1);
    test_end_req = 1'b1;
    step();
    test_end_req = 1'b0;
    step();
    step();
    check_eq("end_stays", {30'd0, test_ending, test_has_ended}, 32'd3);
    check_eq("sb_drain_b", sb.size(), 32'd0);

    // Async reset mid-frame while ENDING.
    do_reset();
    pif.frame_ready = 1'b0;
    send(2'd1, 1'b1);
    send(2'd3, 1'b1);
    send(2'd2, 1'b1);
    test_end_req = 1'b1;
    model_flush();
    step();
    test_end_req = 1'b0;
    check_eq("ar_pre", {30'd0, pif.frame_valid, test_ending}, 32'd3);
    #3;
    reset_n = 1'b0;
    #1;
    check_eq("ar_fv", {31'd0, pif.frame_valid}, 32'd0);
    check_eq("ar_fdata", {2'b0, pif.frame_data}, 32'd0);
    check_eq("ar_fcnt", {28'd0, pif.frame_count}, 32'd0);
    check_eq("ar_acc", {dct_count, dct_buffer[27:0]}, 32'd0);
    check_eq("ar_flags", {29'd0, overflow, test_ending, test_has_ended}, 32'd0);
    sb.delete();
    model_clear();
    step();
    reset_n = 1'b1;
    step();
    check_eq("ar_run", {31'd0, test_ending}, 32'd0);
    pif.frame_ready = 1'b1;
    send(2'd2, 1'b1);
    check_eq("ar_accept", {28'd0, dct_count}, 32'd1);
    flush = 1'b1;
    model_flush();
    step();
    flush = 1'b0;
    step();
    step();
    check_eq("sb_drain_c", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
